// File: rtl/jpeg_idct_transpose_ctrl.sv
// Ping-pong transpose buffer between the IDCT row and column passes: one RAM bank fills in
// linear order while the other drains (column-major when OUT_TRANSPOSE=1) through a 2-entry skid FIFO.
module jpeg_idct_transpose_ctrl #(
  parameter bit OUT_TRANSPOSE  = 1'b1,
  parameter int OUT_FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inport_valid_i,
  input  logic [15:0] inport_data_i,
  output logic        inport_accept_o,
  output logic        outport_valid_o,
  output logic [15:0] outport_data_o,
  output logic        outport_last_o,
  input  logic        outport_accept_i,
  output logic [5:0]  bank_a_addr0_o,
  output logic [15:0] bank_a_data0_o,
  output logic        bank_a_wr0_o,
  output logic [5:0]  bank_a_addr1_o,
  input  logic [15:0] bank_a_data1_i,
  output logic [5:0]  bank_b_addr0_o,
  output logic [15:0] bank_b_data0_o,
  output logic        bank_b_wr0_o,
  output logic [5:0]  bank_b_addr1_o,
  input  logic [15:0] bank_b_data1_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_e;

  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } fifo_entry_t;

  bank_state_e state_q [2];
  bank_state_e state_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [5:0]  wr_cnt_q, wr_cnt_d;
  logic [5:0]  rd_cnt_q, rd_cnt_d;
  logic [5:0]  addr1_q [2];
  logic [5:0]  addr1_d [2];
  logic        inflight_q, inflight_d;
  logic        inflight_bank_q, inflight_bank_d;
  logic        inflight_last_q, inflight_last_d;
  fifo_entry_t fifo_q [2];
  fifo_entry_t fifo_d [2];
  logic        fifo_wr_q, fifo_wr_d;
  logic        fifo_rd_q, fifo_rd_d;
  logic [1:0]  fifo_cnt_q, fifo_cnt_d;

  logic        wr_fire;
  logic        rd_issue;
  logic        fifo_push;
  logic        fifo_pop;
  logic [1:0]  held;
  logic [5:0]  rd_addr;
  fifo_entry_t push_entry;

  // Register process.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= BANK_EMPTY;
        addr1_q[b] <= '0;
        // NOTE: only the small skid storage is reset so the output port reads 0 during reset;
        // the external RAM banks are never cleared and their stale contents are never read.
        fifo_q[b]  <= '0;
      end
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      wr_cnt_q        <= '0;
      rd_cnt_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_bank_q <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_wr_q       <= 1'b0;
      fifo_rd_q       <= 1'b0;
      fifo_cnt_q      <= '0;
    end else begin
      // NOTE: non-blocking updates make every flop sample the same pre-edge values.
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= state_d[b];
        addr1_q[b] <= addr1_d[b];
        fifo_q[b]  <= fifo_d[b];
      end
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_cnt_q        <= wr_cnt_d;
      rd_cnt_q        <= rd_cnt_d;
      inflight_q      <= inflight_d;
      inflight_bank_q <= inflight_bank_d;
      inflight_last_q <= inflight_last_d;
      fifo_wr_q       <= fifo_wr_d;
      fifo_rd_q       <= fifo_rd_d;
      fifo_cnt_q      <= fifo_cnt_d;
    end
  end

  // Output / handshake process. Input accept depends on registered bank state only.
  always_comb begin
    inport_accept_o = rst_i && ((state_q[wr_ptr_q] == BANK_EMPTY) ||
                                (state_q[wr_ptr_q] == BANK_FILLING));
    wr_fire         = inport_valid_i && inport_accept_o;

    outport_valid_o = (fifo_cnt_q != 2'd0);
    outport_data_o  = fifo_q[fifo_rd_q].data;
    outport_last_o  = fifo_q[fifo_rd_q].last;
    fifo_pop        = outport_valid_o && outport_accept_i;

    fifo_push       = inflight_q;
    push_entry.last = inflight_last_q;
    push_entry.data = inflight_bank_q ? bank_b_data1_i : bank_a_data1_i;

    // A same-cycle pop frees a slot, which keeps one word per cycle flowing with accept high.
    held     = fifo_cnt_q + {1'b0, inflight_q};
    rd_issue = ((state_q[rd_ptr_q] == BANK_FULL) || (state_q[rd_ptr_q] == BANK_DRAINING)) &&
               ((held < 2'(OUT_FIFO_DEPTH)) || fifo_pop);
    rd_addr  = OUT_TRANSPOSE ? {rd_cnt_q[2:0], rd_cnt_q[5:3]} : rd_cnt_q;

    bank_a_wr0_o   = wr_fire && !wr_ptr_q;
    bank_b_wr0_o   = wr_fire && wr_ptr_q;
    bank_a_addr0_o = wr_cnt_q;
    bank_b_addr0_o = wr_cnt_q;
    bank_a_data0_o = bank_a_wr0_o ? inport_data_i : '0;
    bank_b_data0_o = bank_b_wr0_o ? inport_data_i : '0;
    bank_a_addr1_o = (rd_issue && !rd_ptr_q) ? rd_addr : addr1_q[0];
    bank_b_addr1_o = (rd_issue && rd_ptr_q)  ? rd_addr : addr1_q[1];

    busy_o = (state_q[0] != BANK_EMPTY) || (state_q[1] != BANK_EMPTY) || (fifo_cnt_q != 2'd0);
  end

  // Next-state process.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      // NOTE: each comb output is assigned a default before any branch, so no latch is inferred.
      state_d[b] = state_q[b];
      case (state_q[b])
        BANK_EMPTY:
          if (wr_fire && (wr_ptr_q == 1'(b))) state_d[b] = BANK_FILLING;
        BANK_FILLING:
          if (wr_fire && (wr_ptr_q == 1'(b)) && (wr_cnt_q == 6'd63)) state_d[b] = BANK_FULL;
        BANK_FULL:
          if (rd_issue && (rd_ptr_q == 1'(b))) state_d[b] = BANK_DRAINING;
        BANK_DRAINING:
          if (rd_issue && (rd_ptr_q == 1'(b)) && (rd_cnt_q == 6'd63)) state_d[b] = BANK_EMPTY;
        default:
          state_d[b] = BANK_EMPTY;
      endcase
      addr1_d[b] = (rd_issue && (rd_ptr_q == 1'(b))) ? rd_addr : addr1_q[b];
      fifo_d[b]  = fifo_q[b];
    end

    wr_cnt_d = wr_fire ? wr_cnt_q + 6'd1 : wr_cnt_q;
    wr_ptr_d = wr_ptr_q ^ (wr_fire && (wr_cnt_q == 6'd63));
    rd_cnt_d = rd_issue ? rd_cnt_q + 6'd1 : rd_cnt_q;
    rd_ptr_d = rd_ptr_q ^ (rd_issue && (rd_cnt_q == 6'd63));

    inflight_d      = rd_issue;
    inflight_bank_d = rd_issue ? rd_ptr_q : inflight_bank_q;
    inflight_last_d = rd_issue && (rd_cnt_q == 6'd63);

    if (fifo_push) fifo_d[fifo_wr_q] = push_entry;
    fifo_wr_d  = fifo_wr_q ^ fifo_push;
    fifo_rd_d  = fifo_rd_q ^ fifo_pop;
    fifo_cnt_d = fifo_cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
  end

endmodule

// File: doc/jpeg_idct_transpose_ctrl.md
Name: jpeg_idct_transpose_ctrl

Overview:
Ping-pong controller for two 64x16 dual-port IDCT RAM banks (bank A, bank B) between the IDCT row pass and the column pass. It writes an incoming 64-coefficient stream into one bank in linear order. At the same time it drains the other full bank in transposed (column-major) order through a valid/accept output stream with full backpressure. Port 0 of each bank is write-only and port 1 is read-only; both ports are tied to clk_i.

Parameters:
OUT_TRANSPOSE, 1, 1 = read address {k[2:0],k[5:3]}; 0 = linear read address k
OUT_FIFO_DEPTH, 2, output skid FIFO entries (fixed at 2; other values are not supported)

Ports:
clk_i  input  1  single clock; also drives both RAM clocks
rst_i  input  1  asynchronous, active-low reset
inport_valid_i  input  1  input coefficient valid
inport_data_i  input  16  input coefficient
inport_accept_o  output  1  input handshake accept
outport_valid_o  output  1  output valid
outport_data_o  output  16  output coefficient
outport_last_o  output  1  high on the 64th output word of a block
outport_accept_i  input  1  output handshake accept
bank_a_addr0_o  output  6  bank A write address
bank_a_data0_o  output  16  bank A write data
bank_a_wr0_o  output  1  bank A write strobe
bank_a_addr1_o  output  6  bank A read address
bank_a_data1_i  input  16  bank A read data (registered in RAM, 1-cycle latency)
bank_b_addr0_o / bank_b_data0_o / bank_b_wr0_o / bank_b_addr1_o / bank_b_data1_i  same as bank A
busy_o  output  1  high if any bank is non-EMPTY or the output FIFO is non-empty

Behaviour:
- Per-bank state: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
  - EMPTY -> FILLING on the first input handshake.
  - FILLING -> FULL on the 64th write.
  - FULL -> DRAINING on the first read issue.
  - DRAINING -> EMPTY on the cycle after the 64th read issue.
- Reset (asynchronous, rst_i=0):
  - Both banks EMPTY; wr_ptr=A, rd_ptr=A; wr_cnt=0, rd_cnt=0.
  - FIFO empty, no read in flight.
  - All outputs 0, except inport_accept_o=0 while in reset and 1 on the first cycle after release.
- Write side:
  - inport_accept_o = (bank[wr_ptr] is EMPTY or FILLING). It is a registered-state function only, with no combinational path from outport_accept_i.
  - On handshake: wr0 strobe of bank[wr_ptr] asserted the same cycle, addr0 = wr_cnt, data0 = inport_data_i; wr_cnt increments.
  - At wr_cnt=63: wr_cnt wraps to 0 and wr_ptr toggles.
  - The idle bank's wr0 strobe is 0.
- Read side:
  - A read is issued when bank[rd_ptr] is FULL or DRAINING and (fifo_count + inflight) < 2.
  - On issue: addr1 = rd_cnt (transposed per OUT_TRANSPOSE); data returns on data1 next cycle and is pushed into the FIFO with a last flag (rd_cnt==63 at issue).
  - At rd_cnt=63: rd_cnt wraps and rd_ptr toggles.
  - addr1 holds its last value when no read is issued.
- Output:
  - FIFO head drives outport_valid_o, outport_data_o and outport_last_o directly.
  - A pop occurs when valid & accept; a push and a pop may occur in the same cycle.
  - Sustained throughput is 1 word/cycle with accept held high.
- Latency: 64th input handshake in cycle T -> bank FULL at T+1 -> addr1 = 0 at T+1 -> outport_valid_o = 1 at T+3.
- Simultaneous fill and drain:
  - The write bank and the read bank are always distinct while both are active.
  - A bank freed in cycle N is writable from N+1. This is safe because RAM reads are read-first and the data has already been captured.
- Both banks FULL: inport_accept_o = 0 until one bank returns to EMPTY.
- Output stalled: reads stop once 2 words are held (FIFO + in flight). No word is dropped or duplicated.
- Reset mid-operation: all block progress is discarded. RAM contents are not cleared and are not relied on.

Test Plan:
- Single block, inputs 0..63, accept high: outputs 0,8,16,...,56,1,9,...,63. Last output = 63 with last=1. First output valid 3 cycles after the 64th input.
- Two back-to-back blocks (values 0..127), outport_accept_i high: inport_accept_o never drops. All 128 inputs accepted in 128 cycles. Second block outputs start with 64, 72.
- outport_accept_i held 0, 200 input words offered: exactly 128 accepted, then inport_accept_o=0, busy_o=1. Releasing accept drains 128 words in order, then 72 more are accepted.
- Random 50% backpressure on outport_accept_i, 4 blocks of random data: output equals a transpose reference model; last flag on every 64th word; no loss or duplication.
- Assert rst_i=0 mid-drain (after 20 outputs): all outputs 0 asynchronously, busy_o=0. A new block after release produces a correct transposed stream.
- OUT_TRANSPOSE=0, inputs 0..63: outputs 0..63 in linear order.
